sfm_acc_ctrl_mc: RTL
====================

# sfm_acc_ctrl_mc

Multi-channel successor of the softmax accumulator controller. It sequences accumulation, partial-sum reduction and Newton-Raphson reciprocal for N_CH independent denominators that share one FMA datapath. Channels are processed one after another, and the iteration count is chosen at run time. It sits between the softmax top-level controller and the accumulator datapath, and drives only control strobes plus a channel select.

## Interface
Parameters:
- N_CH, 4: number of denominators/channels. Must be ≥ 1.
- MAX_INV_ITERS, 2: largest supported Newton-Raphson iteration count.
- COMB_INV, 0: 1 means the initial reciprocal approximation is combinational, so INVERSION is skipped.
- Derived: CHW = max(1, $clog2(N_CH)); ITW = $clog2(MAX_INV_ITERS+1).

Ports (one clock; reset is asynchronous and active-low):
- clk_i, in, 1: clock.
- rst_ni, in, 1: asynchronous active-low reset.
- clear_i, in, 1: synchronous soft clear. Highest priority.
- acc_finished_i, in, 1: upstream has no more addends.
- acc_only_i, in, 1: skip inversion. Sampled with acc_finished_i.
- n_iters_i, in, ITW: Newton-Raphson iterations. Sampled with acc_finished_i and saturated to MAX_INV_ITERS.
- load_reciprocal_i, in, 1: externally loaded reciprocals; bypass to FINISHED.
- addend_valid_i, in, 1: datapath holds a valid addend.
- pipe_empty_i, in, 1: addend and factor buffers are empty.
- fma_o_valid_i, in, 1: FMA output valid.
- last_op_in_flight_i, in, 1: exactly one partial of the selected channel remains.
- inv_appr_valid_i, in, 1: initial approximation ready.
- ch_sel_o, out, CHW: channel being reduced/inverted.
- reducing_o, inverting_o, inv_fma_o, fma_inv_valid_o, first_inv_iter_o, push_fma_res_o, disable_ready_o, den_enable_o, inv_enable_o, new_inv_iter_o, out, 1 each: datapath strobes.
- acc_done_o, out, 1: 1-cycle pulse when the last channel's reduction completes.
- inv_done_o, out, 1: level; all reciprocals are valid.
- res_valid_o, out, 1: level; same condition as inv_done_o.

## Operation
States: IDLE, COMPUTING, FINISHING, REDUCTION, INVERSION, INV_FMA, INV_MUL, NEXT_CH, FINISHED.

- IDLE:
  - addend_valid_i → COMPUTING.
  - Otherwise load_reciprocal_i → FINISHED.
  - acc_finished_i is ignored.
- COMPUTING: acc_finished_i → FINISHING. Latch acc_only, and latch n_iters saturated to MAX_INV_ITERS.
- FINISHING: when pipe_empty_i & ~addend_valid_i:
  - assert push_fma_res_o and reducing_o;
  - set parity = 1;
  - → REDUCTION.
- REDUCTION:
  - reducing_o = 1 and disable_ready_o = 1.
  - On each fma_o_valid_i: push_fma_res_o = ~parity, then toggle parity.
  - On fma_o_valid_i & last_op_in_flight_i:
    - den_enable_o = 1 and push_fma_res_o = 0.
    - If acc_only: → NEXT_CH.
    - Else: assert inverting_o and inv_enable_o.
      - COMB_INV=1 and n_iters > 0: → INV_FMA with inv_fma_o, fma_inv_valid_o and first_inv_iter_o asserted.
      - COMB_INV=1 and n_iters == 0: → NEXT_CH.
      - COMB_INV=0: → INVERSION.
- INVERSION:
  - inverting_o = 1.
  - On inv_appr_valid_i with n_iters == 0: → NEXT_CH.
  - On inv_appr_valid_i otherwise: → INV_FMA with inv_fma_o, fma_inv_valid_o and first_inv_iter_o asserted.
- INV_FMA: inverting_o = 1. On fma_o_valid_i: fma_inv_valid_o = 1; → INV_MUL.
- INV_MUL:
  - inverting_o = 1.
  - On fma_o_valid_i: new_inv_iter_o = 1 and iter increments.
  - If iter == n_iters-1: → NEXT_CH.
  - Else: → INV_FMA with inv_fma_o and fma_inv_valid_o asserted.
- NEXT_CH (1 cycle):
  - iter and parity clear.
  - If ch_sel_o == N_CH-1: ch clears and acc_done_o pulses; acc_only → IDLE, else → FINISHED.
  - Else: ch increments; → FINISHING, which re-runs the drain check before the next channel.
- FINISHED:
  - res_valid_o = inv_done_o = 1.
  - addend_valid_i → COMPUTING, with ch and iter at 0.
- Counters do not wrap: ch saturates at N_CH-1 and iter at MAX_INV_ITERS-1.
- clear_i or rst_ni forces IDLE, with ch, iter, parity and the latched fields all 0.
- Reset and clear take effect mid-inversion with no completion pulse.
- Unlisted strobes are 0 in each state.

## Timing
- All outputs are combinational from the state, the registers and the *_i flags. The reset value of every output is 0, with ch_sel_o = 0.
- State and counters update on the rising clk_i edge after the triggering condition.
- acc_done_o is exactly 1 cycle, registered through NEXT_CH, and arrives 1 cycle after the final last_op_in_flight_i & fma_o_valid_i.
- For COMB_INV=1 and n_iters=k, inversion of a channel occupies 2k FMA handshakes. COMB_INV=0 adds the wait on inv_appr_valid_i.
- Simultaneous events:
  - clear_i beats everything.
  - In IDLE, addend_valid_i beats load_reciprocal_i.
  - fma_o_valid_i with last_op_in_flight_i completes the reduction; the parity push is suppressed.

## Structure
- The state enum stays local to the module.
- sfm_pkg holds the MAX_INV_ITERS and N_CH defaults, plus an acc_mc_ctrl_t / acc_mc_flags_t pair bundling the strobes for top-level use.
- One sub-module is natural: sfm_acc_ch_iter_cnt, the channel and iteration counters with their saturation and clear logic.

## Test plan
- N_CH=1, COMB_INV=1, n_iters=2, acc_only=0: full flow → 4 fma_o_valid handshakes in inversion; new_inv_iter_o pulses twice; inv_done_o high.
- N_CH=4, acc_only=1: last_op_in_flight_i with fma_o_valid_i per channel → den_enable_o 4 times with ch_sel_o 0,1,2,3; acc_done_o once; back in IDLE.
- COMB_INV=0, n_iters=0: inv_appr_valid_i → NEXT_CH directly; fma_inv_valid_o never asserts.
- Reduction of 4 partials: fma_o_valid_i on cycles 0,1,2 with last_op_in_flight_i on cycle 2 → push_fma_res_o 0,1,0 in REDUCTION.
- clear_i in INV_MUL of channel 2 → IDLE next cycle; ch_sel_o=0; acc_done_o and inv_done_o stay 0.
- load_reciprocal_i in IDLE → FINISHED; addend_valid_i then → COMPUTING.

Source files
------------

// File: rtl/sfm_pkg.sv
// sfm_pkg: shared defaults, strobe bundles and helpers for the softmax accumulator controller
package sfm_pkg;
  localparam int SFM_N_CH = 4;
  localparam int SFM_MAX_INV_ITERS = 2;

  typedef struct packed {
    logic reducing;
    logic inverting;
    logic inv_fma;
    logic fma_inv_valid;
    logic first_inv_iter;
    logic push_fma_res;
    logic disable_ready;
    logic den_enable;
    logic inv_enable;
    logic new_inv_iter;
    logic acc_done;
    logic inv_done;
    logic res_valid;
  } acc_mc_ctrl_t;

  typedef struct packed {
    logic clear;
    logic acc_finished;
    logic acc_only;
    logic load_reciprocal;
    logic addend_valid;
    logic pipe_empty;
    logic fma_o_valid;
    logic last_op_in_flight;
    logic inv_appr_valid;
  } acc_mc_flags_t;

  function automatic int sat_iters(input int n, input int max_n);
    return (n > max_n) ? max_n : n;
  endfunction
endpackage

// File: rtl/sfm_acc_ctrl_mc_ch_iter_cnt.sv
// sfm_acc_ch_iter_cnt: saturating channel and Newton-Raphson iteration counters
module sfm_acc_ch_iter_cnt #(
  parameter int N_CH = 4,
  parameter int MAX_INV_ITERS = 2,
  parameter int CHW = 2,
  parameter int ITW = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clear_i,
  input  logic           ch_inc_i,
  input  logic           ch_clr_i,
  input  logic           it_inc_i,
  input  logic           it_clr_i,
  output logic [CHW-1:0] ch_o,
  output logic [ITW-1:0] it_o
);
  localparam logic [CHW-1:0] CH_MAX = CHW'(N_CH - 1);
  localparam logic [ITW-1:0] IT_MAX = ITW'(MAX_INV_ITERS - 1);

  // channel select, holds at the last channel instead of wrapping
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ch_o <= '0;
    else if (clear_i || ch_clr_i) ch_o <= '0;
    else if (ch_inc_i && ch_o != CH_MAX) ch_o <= ch_o + CHW'(1);

  // iteration index, holds at the largest supported iteration
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) it_o <= '0;
    else if (clear_i || it_clr_i) it_o <= '0;
    else if (it_inc_i && it_o != IT_MAX) it_o <= it_o + ITW'(1);
endmodule

// File: rtl/sfm_acc_ctrl_mc.sv
// sfm_acc_ctrl_mc: per-channel accumulate, reduce and reciprocal sequencer over a shared FMA
module sfm_acc_ctrl_mc
  import sfm_pkg::*;
#(
  parameter int N_CH = SFM_N_CH,
  parameter int MAX_INV_ITERS = SFM_MAX_INV_ITERS,
  parameter bit COMB_INV = 1'b0,
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int ITW = $clog2(MAX_INV_ITERS + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clear_i,
  input  logic           acc_finished_i,
  input  logic           acc_only_i,
  input  logic [ITW-1:0] n_iters_i,
  input  logic           load_reciprocal_i,
  input  logic           addend_valid_i,
  input  logic           pipe_empty_i,
  input  logic           fma_o_valid_i,
  input  logic           last_op_in_flight_i,
  input  logic           inv_appr_valid_i,
  output logic [CHW-1:0] ch_sel_o,
  output logic           reducing_o,
  output logic           inverting_o,
  output logic           inv_fma_o,
  output logic           fma_inv_valid_o,
  output logic           first_inv_iter_o,
  output logic           push_fma_res_o,
  output logic           disable_ready_o,
  output logic           den_enable_o,
  output logic           inv_enable_o,
  output logic           new_inv_iter_o,
  output logic           acc_done_o,
  output logic           inv_done_o,
  output logic           res_valid_o
);
  typedef enum logic [3:0] {
    IDLE, COMPUTING, FINISHING, REDUCTION, INVERSION, INV_FMA, INV_MUL, NEXT_CH, FINISHED
  } state_e;

  localparam logic [CHW-1:0] CH_LAST = CHW'(N_CH - 1);

  state_e state_q, state_d;
  acc_mc_ctrl_t c;
  logic par_q, par_d, acc_only_q;
  logic [ITW-1:0] n_iters_q, it;
  logic ch_inc, ch_clr, it_inc, it_clr;

  sfm_acc_ch_iter_cnt #(
    .N_CH(N_CH), .MAX_INV_ITERS(MAX_INV_ITERS), .CHW(CHW), .ITW(ITW)
  ) u_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .ch_inc_i(ch_inc), .ch_clr_i(ch_clr), .it_inc_i(it_inc), .it_clr_i(it_clr),
    .ch_o(ch_sel_o), .it_o(it)
  );

  // state, reduction parity and the fields captured when accumulation ends
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      par_q <= 1'b0;
      acc_only_q <= 1'b0;
      n_iters_q <= '0;
    end else if (clear_i) begin
      state_q <= IDLE;
      par_q <= 1'b0;
      acc_only_q <= 1'b0;
      n_iters_q <= '0;
    end else begin
      state_q <= state_d;
      par_q <= par_d;
      if (state_q == COMPUTING && acc_finished_i) begin
        acc_only_q <= acc_only_i;
        n_iters_q <= ITW'(sat_iters(int'(n_iters_i), MAX_INV_ITERS));
      end
    end

  // next state, datapath strobes and counter controls
  always_comb begin
    state_d = state_q;
    par_d = par_q;
    c = '0;
    ch_inc = 1'b0;
    ch_clr = 1'b0;
    it_inc = 1'b0;
    it_clr = 1'b0;
    if (clear_i) state_d = IDLE;
    else case (state_q)
      IDLE: state_d = addend_valid_i ? COMPUTING : load_reciprocal_i ? FINISHED : IDLE;
      COMPUTING: if (acc_finished_i) state_d = FINISHING;
      FINISHING: if (pipe_empty_i && !addend_valid_i) begin
        c.push_fma_res = 1'b1;
        c.reducing = 1'b1;
        par_d = 1'b1;
        state_d = REDUCTION;
      end
      REDUCTION: begin
        c.reducing = 1'b1;
        c.disable_ready = 1'b1;
        if (fma_o_valid_i) par_d = ~par_q;
        if (fma_o_valid_i && last_op_in_flight_i) begin
          c.den_enable = 1'b1;
          if (acc_only_q) state_d = NEXT_CH;
          else begin
            c.inverting = 1'b1;
            c.inv_enable = 1'b1;
            if (!COMB_INV) state_d = INVERSION;
            else if (n_iters_q == '0) state_d = NEXT_CH;
            else begin
              c.inv_fma = 1'b1;
              c.fma_inv_valid = 1'b1;
              c.first_inv_iter = 1'b1;
              state_d = INV_FMA;
            end
          end
        end else if (fma_o_valid_i) c.push_fma_res = ~par_q;
      end
      INVERSION: begin
        c.inverting = 1'b1;
        if (inv_appr_valid_i && n_iters_q == '0) state_d = NEXT_CH;
        else if (inv_appr_valid_i) begin
          c.inv_fma = 1'b1;
          c.fma_inv_valid = 1'b1;
          c.first_inv_iter = 1'b1;
          state_d = INV_FMA;
        end
      end
      INV_FMA: begin
        c.inverting = 1'b1;
        if (fma_o_valid_i) begin
          c.fma_inv_valid = 1'b1;
          state_d = INV_MUL;
        end
      end
      INV_MUL: begin
        c.inverting = 1'b1;
        if (fma_o_valid_i) begin
          c.new_inv_iter = 1'b1;
          it_inc = 1'b1;
          if (it == n_iters_q - ITW'(1)) state_d = NEXT_CH;
          else begin
            c.inv_fma = 1'b1;
            c.fma_inv_valid = 1'b1;
            state_d = INV_FMA;
          end
        end
      end
      NEXT_CH: begin
        it_clr = 1'b1;
        par_d = 1'b0;
        if (ch_sel_o == CH_LAST) begin
          ch_clr = 1'b1;
          c.acc_done = 1'b1;
          state_d = acc_only_q ? IDLE : FINISHED;
        end else begin
          ch_inc = 1'b1;
          state_d = FINISHING;
        end
      end
      FINISHED: begin
        c.inv_done = 1'b1;
        c.res_valid = 1'b1;
        if (addend_valid_i) begin
          ch_clr = 1'b1;
          it_clr = 1'b1;
          state_d = COMPUTING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign reducing_o = c.reducing;
  assign inverting_o = c.inverting;
  assign inv_fma_o = c.inv_fma;
  assign fma_inv_valid_o = c.fma_inv_valid;
  assign first_inv_iter_o = c.first_inv_iter;
  assign push_fma_res_o = c.push_fma_res;
  assign disable_ready_o = c.disable_ready;
  assign den_enable_o = c.den_enable;
  assign inv_enable_o = c.inv_enable;
  assign new_inv_iter_o = c.new_inv_iter;
  assign acc_done_o = c.acc_done;
  assign inv_done_o = c.inv_done;
  assign res_valid_o = c.res_valid;
endmodule
